fm_meas_seq: RTL
================

# fm_meas_seq

Measurement sequencer for the FM demodulator path. It gates the demodulator's `en`, waits for the FIR chain to settle, then measures the demodulated output over a fixed gate window. From that window it derives the modulating frequency (rising zero-crossing count), the peak-to-peak swing and the maximum deviation. It computes the modulation index with an internal serial divider. It sits between the front-panel or UART command logic and the demodulator, and replaces free-running estimation with one explicit start/done transaction.

## Interface
- `SETTLE_CYCLES`, 4096: cycles to wait after `demod_en` rises before measuring.
- `GATE_CYCLES`, 32000000: measurement window. At 32 MHz this is 1 s, so the crossing count equals Hz.
- `HYST`, 16: zero-crossing hysteresis in LSB around mid-scale 512.
- `HZ_PER_LSB`, 100: deviation scale in Hz per demod-output LSB, 8-bit unsigned.
- `clk_32m`, in, 1: system clock.
- `rst`, in, 1: reset, synchronous, active-high.
- `start`, in, 1: one-cycle request; honoured only in IDLE.
- `abort`, in, 1: return to IDLE from any state.
- `demod_out`, in, 10: unsigned demodulator output, offset binary, mid-scale 512.
- `demod_en`, out, 1: drives demodulator `en`.
- `busy`, out, 1: high in every state except IDLE.
- `done`, out, 1: one-cycle pulse when results update.
- `err`, out, 1: last measurement saw zero crossings; held until next `done`.
- `mod_freq`, out, 13: crossings per gate, saturating at 8191.
- `delta_f`, out, 16: maximum deviation in Hz, saturating at 65535.
- `mf`, out, 8: modulation index, unsigned Q4.4, saturating at 255.

## Operation
- States: IDLE, SETTLE, MEASURE, DIVIDE, DONE.
- IDLE: `demod_en`=0.
  - `start`=1 moves to SETTLE and clears the cycle counter, max=0, min=1023, crossing count=0, and the armed flag.
- SETTLE: `demod_en`=1.
  - Counts `SETTLE_CYCLES`, then moves to MEASURE with the counter cleared.
- MEASURE: `demod_en`=1. Every cycle it:
  - updates max/min with `demod_out`;
  - sets armed when `demod_out` < 512−`HYST`;
  - when armed and `demod_out` > 512+`HYST`, increments the crossing count (saturating at 8191) and clears armed.
  - After exactly `GATE_CYCLES` samples it moves to DIVIDE.
- DIVIDE: `demod_en`=1. Entry computes:
  - vpp = max−min, 10 bits;
  - dev = (vpp × `HZ_PER_LSB`) >> 1, 17 bits, saturated to 16 bits into delta_f.
  - Dividend = delta_f << 4 (20 bits), divisor = crossing count.
  - Restoring divider, one quotient bit per cycle, 20 cycles.
  - Quotient > 255 gives `mf`=255.
  - Crossing count = 0: skip the divider, quotient=0, set `err`.
- DONE: registers `mod_freq`, `delta_f`, `mf` and `err`, and pulses `done` for one cycle.
  - Then returns to IDLE.
- `start` outside IDLE is ignored.
- `abort` has priority over every transition: next state is IDLE, `demod_en` falls, and result outputs keep their previous values with no `done`.
- `start` and `abort` in the same IDLE cycle: `abort` wins and the block stays in IDLE.
- `rst` mid-operation behaves like `abort` but also zeroes all outputs.

## Timing
- Reset values: `demod_en`=0, `busy`=0, `done`=0, `err`=0, `mod_freq`=0, `delta_f`=0, `mf`=0; state IDLE.
- `demod_en` and `busy` rise on the clock edge that samples `start`.
- First MEASURE sample is taken `SETTLE_CYCLES` cycles after that edge.
- Latency from `start` edge to `done` high: `SETTLE_CYCLES` + `GATE_CYCLES` + 20 + 1 cycles. With zero crossings the 20 divider cycles are replaced by 1.
- Outputs change only in the cycle `done` is high.
- `busy` falls one cycle after `done`.

## Configuration
- `FM_MEAS_CONT_EN` defined: DONE goes straight to MEASURE instead of IDLE.
  - Counters, max/min and armed are cleared; no re-settle.
  - `demod_en` and `busy` stay high, and `done` pulses once per gate until `abort`.
- `FM_MEAS_CONT_EN` undefined: single-shot behaviour as above.

## Test plan
- Reset: hold `rst` 3 cycles, then release -> all outputs 0, `demod_en`=0; `start` ignored while `rst`=1.
- Nominal run (`SETTLE_CYCLES`=4, `GATE_CYCLES`=1000, `HZ_PER_LSB`=1): square wave at 492/532, period 100 cycles -> `done` at cycle 1025, `mod_freq`=10, `delta_f`=20, `mf`=32 (2.0), `err`=0.
- Saturation (`HZ_PER_LSB`=100): square wave at 300/724, period 100 -> `delta_f`=21200, `mod_freq`=10, `mf`=255.
- Hysteresis/no signal: constant 512 plus ±10 LSB noise, `HYST`=16 -> `mod_freq`=0, `err`=1, `mf`=0; `done` at cycle 1006.
- Abort: `abort` at cycle 500 of MEASURE -> next cycle IDLE, `demod_en`=0, no `done`, outputs hold previous values; a new `start` then completes normally.
- Continuous mode (`FM_MEAS_CONT_EN`): nominal stimulus -> `done` at cycles 1025, 2046 and 3067 with identical results; `start` pulses during the run are ignored.

Source files
------------

// File: rtl/fm_meas_seq.sv
// rtl/fm_meas_seq.sv - FM demod measurement sequencer: settle, gate window, serial divide
// Define FM_MEAS_CONT_EN to re-enter MEASURE after every result instead of returning to IDLE.
module fm_meas_seq #(
  parameter int unsigned SETTLE_CYCLES = 4096,
  parameter int unsigned GATE_CYCLES   = 32000000,
  parameter int unsigned HYST          = 16,
  parameter int unsigned HZ_PER_LSB    = 100
) (
  input  logic        clk_32m,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic [9:0]  demod_out,
  output logic        demod_en,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [12:0] mod_freq,
  output logic [15:0] delta_f,
  output logic [7:0]  mf
);

  localparam int unsigned CNT_MAX = (SETTLE_CYCLES > GATE_CYCLES) ? SETTLE_CYCLES : GATE_CYCLES;
  localparam int CNT_W = (CNT_MAX > 21) ? $clog2(CNT_MAX) : 5;
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GATE_LAST   = CNT_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LAST    = CNT_W'(20);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [9:0]       LO_TH       = 10'(512 - HYST);
  localparam logic [9:0]       HI_TH       = 10'(512 + HYST);
  localparam logic [7:0]       HZ8         = 8'(HZ_PER_LSB);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_MEASURE,
    S_DIVIDE,
    S_DONE
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [9:0]       max_q, min_q;
  logic             armed_q;
  logic [12:0]      xcnt_q;
  logic [15:0]      dev_q;
  logic [12:0]      rem_q;
  logic [19:0]      quo_q;
  logic             demod_en_q, busy_q, done_q, err_q;
  logic [12:0]      mod_freq_q;
  logic [15:0]      delta_f_q;
  logic [7:0]       mf_q;

  logic [9:0]  max_d, min_d, vpp;
  logic        armed_d;
  logic [12:0] xcnt_d;
  logic [17:0] prod;
  logic [16:0] dev17;
  logic [15:0] dev_sat;
  logic [13:0] rem_sh;
  logic        fits;
  logic [12:0] rem_d;
  logic [19:0] quo_d;
  logic [7:0]  mf_sat;

  always_comb begin
    max_d   = (demod_out > max_q) ? demod_out : max_q;
    min_d   = (demod_out < min_q) ? demod_out : min_q;
    armed_d = armed_q;
    xcnt_d  = xcnt_q;
    // A crossing needs a visit below the low threshold before the high one.
    if (demod_out < LO_TH) begin
      armed_d = 1'b1;
    end else if (armed_q && (demod_out > HI_TH)) begin
      armed_d = 1'b0;
      if (xcnt_q != 13'h1fff) xcnt_d = xcnt_q + 13'd1;
    end

    vpp     = max_q - min_q;
    prod    = {8'b0, vpp} * {10'b0, HZ8};
    dev17   = 17'(prod >> 1);
    dev_sat = dev17[16] ? 16'hffff : dev17[15:0];

    // Restoring step: remainder stays below the divisor, so 13 bits suffice.
    rem_sh = {rem_q, quo_q[19]};
    fits   = (rem_sh >= {1'b0, xcnt_q});
    rem_d  = fits ? (rem_sh[12:0] - xcnt_q) : rem_sh[12:0];
    quo_d  = {quo_q[18:0], fits};
    mf_sat = (|quo_d[19:8]) ? 8'hff : quo_d[7:0];
  end

  always_ff @(posedge clk_32m) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      max_q      <= '0;
      min_q      <= 10'h3ff;
      armed_q    <= 1'b0;
      xcnt_q     <= '0;
      dev_q      <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      demod_en_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      mod_freq_q <= '0;
      delta_f_q  <= '0;
      mf_q       <= '0;
    end else begin
      done_q <= 1'b0;
      if (abort) begin
        state_q    <= S_IDLE;
        demod_en_q <= 1'b0;
        busy_q     <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (start) begin
              state_q    <= S_SETTLE;
              cnt_q      <= '0;
              max_q      <= '0;
              min_q      <= 10'h3ff;
              xcnt_q     <= '0;
              armed_q    <= 1'b0;
              demod_en_q <= 1'b1;
              busy_q     <= 1'b1;
            end
          end
          S_SETTLE: begin
            if (cnt_q == SETTLE_LAST) begin
              state_q <= S_MEASURE;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + CNT_ONE;
            end
          end
          S_MEASURE: begin
            max_q   <= max_d;
            min_q   <= min_d;
            armed_q <= armed_d;
            xcnt_q  <= xcnt_d;
            if (cnt_q == GATE_LAST) begin
              state_q <= S_DIVIDE;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + CNT_ONE;
            end
          end
          S_DIVIDE: begin
            if (cnt_q == '0) begin
              dev_q <= dev_sat;
              quo_q <= {dev_sat, 4'b0};
              rem_q <= '0;
              cnt_q <= CNT_ONE;
            end else begin
              if (xcnt_q != '0) begin
                rem_q <= rem_d;
                quo_q <= quo_d;
              end
              // Zero crossings finish after one cycle with the quotient forced to 0.
              if ((xcnt_q == '0) || (cnt_q == DIV_LAST)) begin
                done_q     <= 1'b1;
                mod_freq_q <= xcnt_q;
                delta_f_q  <= dev_q;
                err_q      <= (xcnt_q == '0);
                mf_q       <= (xcnt_q == '0) ? 8'h00 : mf_sat;
`ifdef FM_MEAS_CONT_EN
                state_q    <= S_MEASURE;
                cnt_q      <= '0;
                max_q      <= '0;
                min_q      <= 10'h3ff;
                xcnt_q     <= '0;
                armed_q    <= 1'b0;
`else
                state_q    <= S_DONE;
`endif
              end else begin
                cnt_q <= cnt_q + CNT_ONE;
              end
            end
          end
          S_DONE: begin
            state_q    <= S_IDLE;
            demod_en_q <= 1'b0;
            busy_q     <= 1'b0;
          end
          default: begin
            state_q    <= S_IDLE;
            demod_en_q <= 1'b0;
            busy_q     <= 1'b0;
          end
        endcase
      end
    end
  end

  assign demod_en = demod_en_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;
  assign mod_freq = mod_freq_q;
  assign delta_f  = delta_f_q;
  assign mf       = mf_q;

endmodule
